// File: rtl/mips_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
//   master : the control FSM (reads instruction/Zero, drives all control strobes)
//   slave  : the datapath side (drives instruction/Zero, reads control strobes)
interface mips_control_fsm_if;
    logic [31:0] instruction;
    logic        Zero;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        branch_taken;
    logic        IorD;
    logic        IRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUScr;
    logic [3:0]  ALUControl;
    logic        instr_done;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  instruction, Zero,
        output PCWrite, PCWriteCond, branch_taken, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUScr, ALUControl, instr_done, illegal, state
    );

    modport slave (
        output instruction, Zero,
        input  PCWrite, PCWriteCond, branch_taken, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUScr, ALUControl, instr_done, illegal, state
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit (lw, sw, R-type add/sub/and/or/slt, beq).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; forces every control output to 0
//   bus  - mips_control_fsm_if.master: instruction/Zero in, control strobes,
//          ALUControl, instr_done, illegal and debug state out
// Outputs are Moore decodes of the state and the internal IR; branch_taken
// additionally folds in Zero.
module mips_control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_control_fsm_if.master    bus
);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        HALT   = 4'd9
    } state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] funct_q;

    logic                pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
    logic                mem_to_reg, reg_dst, reg_write, alu_src, instr_done, illegal;
    logic [ALUC_W-1:0]   alu_control;
    logic                funct_legal;
    logic [ALUC_W-1:0]   funct_alu;

    // Only opcode and funct steer control; the register/immediate fields are the datapath's.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instruction[25:6];

    // R-type funct decode shared by DECODE (legality) and EXEC/ALUWB (operation).
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct_q)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default: begin
                funct_legal = 1'b0;
                funct_alu   = ALU_AND;
            end
        endcase
    end

    // State register and IR (opcode/funct), loaded on the edge leaving FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                op_q    <= bus.instruction[31:26];
                funct_q <= bus.instruction[5:0];
            end
        end
    end

    // Next state and Moore outputs; everything stays 0 while rst is high.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src       = 1'b0;
        alu_control   = ALU_AND;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read    = 1'b1;
                    ir_write    = 1'b1;
                    pc_write    = 1'b1;
                    alu_control = ALU_ADD;
                    state_d     = DECODE;
                end
                DECODE: begin
                    if (op_q == OP_LW || op_q == OP_SW) begin
                        state_d = MEMADR;
                    end else if (op_q == OP_RTYPE && funct_legal) begin
                        state_d = EXEC;
                    end else if (op_q == OP_BEQ) begin
                        state_d = BRANCH;
                    end else begin
                        illegal = 1'b1;
                        if (ILLEGAL_HALT) begin
                            state_d = HALT;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                end
                MEMADR: begin
                    alu_src     = 1'b1;
                    alu_control = ALU_ADD;
                    state_d     = (op_q == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    state_d  = MEMWB;
                end
                MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                EXEC: begin
                    alu_control = funct_alu;
                    state_d     = ALUWB;
                end
                ALUWB: begin
                    reg_dst     = 1'b1;
                    reg_write   = 1'b1;
                    alu_control = funct_alu;
                    instr_done  = 1'b1;
                    state_d     = FETCH;
                end
                BRANCH: begin
                    alu_control   = ALU_SUB;
                    pc_write_cond = 1'b1;
                    instr_done    = 1'b1;
                    state_d       = FETCH;
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign bus.PCWrite      = pc_write;
    assign bus.PCWriteCond  = pc_write_cond;
    assign bus.branch_taken = pc_write_cond & bus.Zero;
    assign bus.IorD         = iord;
    assign bus.IRWrite      = ir_write;
    assign bus.MemRead      = mem_read;
    assign bus.MemWrite     = mem_write;
    assign bus.MemtoReg     = mem_to_reg;
    assign bus.RegDst       = reg_dst;
    assign bus.RegWrite     = reg_write;
    assign bus.ALUScr       = alu_src;
    assign bus.ALUControl   = alu_control;
    assign bus.instr_done   = instr_done;
    assign bus.illegal      = illegal;
    assign bus.state        = STATE_W'(state_q);
endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: two instances (ILLEGAL_HALT 0 and 1).
// Expected per-cycle control vectors are queued by the stimulus; the monitor
// pops one per DUT at each falling edge (or on an explicit sample event).
module tb_mips_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_control_fsm_if bus0 ();
    mips_control_fsm_if bus1 ();

    mips_control_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mips_control_fsm #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Row layout: {state[3:0], PCWrite, PCWriteCond, branch_taken, IorD, IRWrite,
    //              MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUScr,
    //              ALUControl[3:0], instr_done, illegal}
    localparam logic [20:0] R_ZERO  = 21'd0;
    localparam logic [20:0] R_FETCH = {4'd0, 11'b10001100000, 4'b0010, 2'b00};
    localparam logic [20:0] R_DEC   = {4'd1, 11'b00000000000, 4'b0000, 2'b00};
    localparam logic [20:0] R_ILL0  = {4'd1, 11'b00000000000, 4'b0000, 2'b11};
    localparam logic [20:0] R_ILL1  = {4'd1, 11'b00000000000, 4'b0000, 2'b01};
    localparam logic [20:0] R_HALT  = {4'd9, 11'b00000000000, 4'b0000, 2'b00};
    localparam logic [20:0] R_MADR  = {4'd2, 11'b00000000001, 4'b0010, 2'b00};
    localparam logic [20:0] R_MRD   = {4'd3, 11'b00010100000, 4'b0000, 2'b00};
    localparam logic [20:0] R_MWB   = {4'd4, 11'b00000001010, 4'b0000, 2'b10};
    localparam logic [20:0] R_MWR   = {4'd5, 11'b00010010000, 4'b0000, 2'b10};
    localparam logic [20:0] R_BR_T  = {4'd8, 11'b01100000000, 4'b0110, 2'b10};
    localparam logic [20:0] R_BR_N  = {4'd8, 11'b01000000000, 4'b0110, 2'b10};

    typedef struct {
        logic [20:0] v;
        string       nm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    logic finished = 1'b0;
    event sample_ev;

    logic [20:0] act0, act1;
    assign act0 = {bus0.state, bus0.PCWrite, bus0.PCWriteCond, bus0.branch_taken, bus0.IorD,
                   bus0.IRWrite, bus0.MemRead, bus0.MemWrite, bus0.MemtoReg, bus0.RegDst,
                   bus0.RegWrite, bus0.ALUScr, bus0.ALUControl, bus0.instr_done, bus0.illegal};
    assign act1 = {bus1.state, bus1.PCWrite, bus1.PCWriteCond, bus1.branch_taken, bus1.IorD,
                   bus1.IRWrite, bus1.MemRead, bus1.MemWrite, bus1.MemtoReg, bus1.RegDst,
                   bus1.RegWrite, bus1.ALUScr, bus1.ALUControl, bus1.instr_done, bus1.illegal};

    task automatic exp0(input logic [20:0] v, input string nm);
        exp_t e;
        e.v = v; e.nm = nm;
        q0.push_back(e);
    endtask

    task automatic exp1(input logic [20:0] v, input string nm);
        exp_t e;
        e.v = v; e.nm = nm;
        q1.push_back(e);
    endtask

    function automatic logic [20:0] r_exec(input logic [3:0] alu);
        return {4'd6, 11'b00000000000, alu, 2'b00};
    endfunction

    function automatic logic [20:0] r_aluwb(input logic [3:0] alu);
        return {4'd7, 11'b00000000110, alu, 2'b10};
    endfunction

    task automatic push_rtype(input logic [3:0] alu, input string nm);
        exp0(R_FETCH, {nm, " fetch"});
        exp0(R_DEC, {nm, " decode"});
        exp0(r_exec(alu), {nm, " exec"});
        exp0(r_aluwb(alu), {nm, " aluwb"});
    endtask

    // Present an instruction during FETCH, scramble it afterwards, run n cycles.
    task automatic issue(input logic [31:0] ins, input logic z, input int n);
        bus0.instruction = ins;
        bus0.Zero = z;
        @(posedge clk); #1;
        bus0.instruction = 32'hFFFF_FFFF;
        repeat (n - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cmp(input logic [20:0] act, input exp_t e, input string who);
        checks++;
        if (act !== e.v) begin
            errors++;
            $display("FAIL %s %s: got state=%0d vec=%h, want state=%0d vec=%h",
                     who, e.nm, act[20:17], act, e.v[20:17], e.v);
        end
    endtask

    // Monitor: one expected row per DUT per sample point.
    always @(negedge clk or sample_ev) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            cmp(act0, e, "dut0");
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            cmp(act1, e, "dut1");
        end
        if (finished) begin
            checks++;
            if (q0.size() + q1.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d rows left, want 0", q0.size() + q1.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.instruction = 32'h8C08_0005;
        bus0.Zero = 1'b0;
        bus1.instruction = 32'hFC00_0000;
        bus1.Zero = 1'b0;
        // Reset held: FETCH strobes must be suppressed.
        repeat (2) begin
            @(posedge clk); #1;
            exp0(R_ZERO, "reset");
            exp1(R_ZERO, "reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // dut1: illegal opcode parks in HALT.
        exp1(R_FETCH, "halt fetch");
        exp1(R_ILL1, "halt illegal");
        repeat (3) exp1(R_HALT, "halt hold");

        // lw: 5 cycles
        exp0(R_FETCH, "lw fetch"); exp0(R_DEC, "lw decode"); exp0(R_MADR, "lw memadr");
        exp0(R_MRD, "lw memrd"); exp0(R_MWB, "lw memwb");
        issue(32'h8C08_0005, 1'b0, 5);

        push_rtype(4'b0010, "add"); issue(32'h0232_4820, 1'b0, 4);
        push_rtype(4'b0110, "sub"); issue(32'h0232_5022, 1'b0, 4);
        push_rtype(4'b0000, "and"); issue(32'h0232_4824, 1'b0, 4);
        push_rtype(4'b0001, "or");  issue(32'h0232_4825, 1'b0, 4);
        push_rtype(4'b0111, "slt"); issue(32'h0232_482A, 1'b0, 4);

        // sw: 4 cycles
        exp0(R_FETCH, "sw fetch"); exp0(R_DEC, "sw decode"); exp0(R_MADR, "sw memadr");
        exp0(R_MWR, "sw memwr");
        issue(32'hAC09_000A, 1'b0, 4);

        // beq taken / not taken: 3 cycles
        exp0(R_FETCH, "beq1 fetch"); exp0(R_DEC, "beq1 decode"); exp0(R_BR_T, "beq1 branch");
        issue(32'h110B_0004, 1'b1, 3);
        exp0(R_FETCH, "beq0 fetch"); exp0(R_DEC, "beq0 decode"); exp0(R_BR_N, "beq0 branch");
        issue(32'h110B_0004, 1'b0, 3);

        // Illegal opcode and illegal R-type funct: 2 cycles, back to FETCH.
        exp0(R_FETCH, "illop fetch"); exp0(R_ILL0, "illop decode");
        issue(32'hFC00_0000, 1'b0, 2);
        exp0(R_FETCH, "illfn fetch"); exp0(R_ILL0, "illfn decode");
        issue(32'h0232_4821, 1'b0, 2);

        // lw aborted by reset during MEMRD.
        exp0(R_FETCH, "abort fetch"); exp0(R_DEC, "abort decode");
        exp0(R_MADR, "abort memadr"); exp0(R_MRD, "abort memrd");
        repeat (4) exp1(R_HALT, "halt before rst");
        bus0.instruction = 32'h8C08_0005;
        @(posedge clk); #1;
        bus0.instruction = 32'hFFFF_FFFF;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        rst = 1'b1;
        exp0(R_ZERO, "async rst");
        exp1(R_ZERO, "async rst");
        #1 -> sample_ev;
        #1;
        exp0(R_ZERO, "rst held");
        exp1(R_ZERO, "rst held");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Recovery after reset on both instances.
        exp1(R_FETCH, "post rst fetch");
        exp1(R_ILL1, "post rst illegal");
        exp1(R_HALT, "post rst halt");
        exp0(R_FETCH, "post rst lw fetch"); exp0(R_DEC, "post rst lw decode");
        exp0(R_MADR, "post rst lw memadr"); exp0(R_MRD, "post rst lw memrd");
        exp0(R_MWB, "post rst lw memwb");
        issue(32'h8C08_0005, 1'b0, 5);
        push_rtype(4'b0110, "post rst sub"); issue(32'h0232_5022, 1'b0, 4);

        finished = 1'b1;
    end
endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 Parameter: ILLEGAL_HALT, 0, 1 = illegal opcode/funct parks FSM in HALT until reset; 0 = return to FETCH.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 instruction  in  32  instruction word from memory; captured only when IRWrite=1.
REQ-005 Zero  in  1  ALU zero flag from datapath.
REQ-006 PCWrite  out  1  unconditional PC update.
REQ-007 PCWriteCond  out  1  conditional PC update (branch).
REQ-008 branch_taken  out  1  PCWriteCond & Zero.
REQ-009 IorD  out  1  memory address select (0 = PC, 1 = ALU result).
REQ-010 IRWrite  out  1  capture instruction into internal IR.
REQ-011 MemRead, MemWrite  out  1 each  data-memory strobes.
REQ-012 MemtoReg, RegDst, RegWrite, ALUScr  out  1 each  datapath controls, same meaning as the datapath ports of equal name.
REQ-013 ALUControl  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-014 instr_done  out  1  one-cycle pulse in the last state of each instruction.
REQ-015 illegal  out  1  one-cycle pulse in DECODE on unsupported opcode or funct.
REQ-016 state  out  4  current state encoding (debug).

Function
REQ-017 States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, HALT 9.
REQ-018 Outputs are Moore: a function of state and internal IR only, except branch_taken (also uses Zero).
REQ-019 FETCH: IorD=0, MemRead=1, IRWrite=1, PCWrite=1, ALUControl=0010; the IR loads instruction on the exiting edge; next state DECODE.
REQ-020 DECODE dispatches on IR[31:26]: 100011 lw or 101011 sw -> MEMADR; 000000 R-type -> EXEC; 000100 beq -> BRANCH; otherwise illegal=1, then -> HALT if ILLEGAL_HALT=1, else -> FETCH with instr_done=1.
REQ-021 R-type funct IR[5:0] must be one of 100000, 100010, 100100, 100101, 101010; any other funct is treated as illegal in DECODE.
REQ-022 MEMADR: ALUScr=1, ALUControl=0010; lw -> MEMRD, sw -> MEMWR.
REQ-023 MEMRD: IorD=1, MemRead=1 -> MEMWB.
REQ-024 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
REQ-025 MEMWR: IorD=1, MemWrite=1, instr_done=1 -> FETCH.
REQ-026 EXEC: ALUScr=0, ALUControl per funct (add 0010, sub 0110, and 0000, or 0001, slt 0111) -> ALUWB.
REQ-027 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, ALUControl held -> FETCH, instr_done=1.
REQ-028 BRANCH: ALUScr=0, ALUControl=0110, PCWriteCond=1, branch_taken=Zero, instr_done=1 -> FETCH.
REQ-029 HALT: all strobes 0, no transitions except via reset.
REQ-030 Cycles per instruction, FETCH to last state inclusive: lw 5, sw 4, R-type 4, beq 3, illegal 2.
REQ-031 Every output not listed for a state is 0 in that state.
REQ-032 MemRead and MemWrite are never 1 together; RegWrite and MemWrite are never 1 together.
REQ-033 Changes on instruction outside FETCH have no effect on outputs.

Reset
REQ-034 While rst=1: state=FETCH, IR=0, and all outputs forced to 0, including FETCH strobes.
REQ-035 Reset asserted mid-instruction aborts immediately, with no further RegWrite or MemWrite.
REQ-036 FETCH outputs appear in the first cycle after rst deasserts.

Verification
REQ-037 Reset, then instruction=8C080005 (lw) -> states 0,1,2,3,4; MEMWB shows RegWrite=1, MemtoReg=1, RegDst=0; instr_done pulses on cycle 5.
REQ-038 instruction=02324820 (add), then 02325022 (sub) -> EXEC/ALUWB with ALUControl=0010, then 0110; RegDst=1 and RegWrite=1 in ALUWB; 4 cycles each.
REQ-039 instruction=AC09000A (sw) -> MEMWR shows MemWrite=1, IorD=1, RegWrite=0; 4 cycles.
REQ-040 instruction=110B0004 (beq) with Zero=1, then again with Zero=0 -> branch_taken=1, then 0, in BRANCH; 3 cycles.
REQ-041 instruction=FC000000 with ILLEGAL_HALT=0 -> illegal pulse, return to FETCH; with ILLEGAL_HALT=1 -> state=9 held until rst.
REQ-042 rst asserted during MEMRD of a lw -> outputs 0 asynchronously, no RegWrite, state=0, then FETCH after release.
